dm_bus_arbiter: RTL and testbench
=================================

DM_BUS_ARBITER -- requirements
Module: dm_bus_arbiter

Interface
REQ-001 Parameter NUM_MSTS, default 4, number of DM bus masters (2..8).
REQ-002 Parameter RR_EN, default 1: 1 = round-robin arbitration, 0 = fixed priority (master 0 highest).
REQ-003 Parameter TMO_CYCLES, default 255, maximum HOLD cycles before forced completion (1..255).
REQ-004 cp2  input  1  the single clock; all state updates on rising edge.
REQ-005 ireset  input  1  reset, asynchronous, active-high.
REQ-006 msts_outs  input  NUM_MSTS*26  per master {ramwe, ramre, ramadr[15:0], ramdout[7:0]}, master 0 in LSBs.
REQ-007 slv_wait  input  1  wait/not-ready from the addressed DM slave.
REQ-008 tmo_clr  input  1  clears the sticky timeout flag.
REQ-009 ramadr/ramdout/ramre/ramwe  output  16/8/1/1  muxed bus of the granted master.
REQ-010 gnt  output  NUM_MSTS  one-hot grant; all zero when no grant.
REQ-011 gnt_num  output  3  index of the granted master; 0 when no grant.
REQ-012 msts_busy  output  NUM_MSTS  per-master stall (cpuwait analog).
REQ-013 tmo_pulse  output  1  one-cycle pulse on forced completion.
REQ-014 tmo_flag  output  1  sticky timeout indication.

Function
REQ-015 A master requests when its ramre or ramwe is 1; ramre and ramwe both set is treated as a write.
REQ-016 FSM states are IDLE and HOLD.
REQ-017 In IDLE the winner is selected combinationally in the same cycle as the request (zero latency).
REQ-018 With RR_EN=1, the search starts at rr_ptr and wraps modulo NUM_MSTS; with RR_EN=0 the lowest index wins.
REQ-019 In IDLE with a winner and slv_wait=0, the access completes that cycle and the FSM stays in IDLE.
REQ-020 On any completion, rr_ptr <= (winner+1) mod NUM_MSTS at the next edge.
REQ-021 In IDLE with a winner and slv_wait=1, the FSM goes to HOLD, the owner index is latched and tmo_cnt <= 1.
REQ-022 In HOLD the grant and bus mux are locked to the owner; new requests are ignored.
REQ-023 In HOLD with slv_wait=0, the access completes and the FSM returns to IDLE.
REQ-024 In HOLD with slv_wait=1, tmo_cnt increments each cycle.
REQ-025 In HOLD, when tmo_cnt==TMO_CYCLES and slv_wait=1, the access is force-completed in that cycle: tmo_pulse=1, tmo_flag set, return to IDLE.
REQ-026 In HOLD, if the owner drops both ramre and ramwe, the FSM aborts to IDLE and rr_ptr advances; no timeout is flagged.
REQ-027 msts_busy[owner] = slv_wait AND NOT forced completion.
REQ-028 msts_busy[i] = 1 for every requesting, non-granted master; 0 for non-requesting masters.
REQ-029 With no grant, the bus outputs are all zero.
REQ-030 tmo_clr clears tmo_flag; a simultaneous timeout set wins over the clear.
REQ-031 tmo_cnt is 8 bits and saturates; it never wraps.

Reset
REQ-032 While ireset=1: FSM=IDLE, rr_ptr=0, owner=0, tmo_cnt=0, tmo_flag=0, tmo_pulse=0.
REQ-033 Outputs derived from these registers take their reset-derived combinational values.
REQ-034 Reset asserted mid-HOLD abandons the access; the first post-reset grant uses rr_ptr=0.

Structure
REQ-035 The bus field width (26), field bit offsets (ramwe=25, ramre=24, ramadr=23:8, ramdout=7:0) and FSM state encodings belong in the shared interconnect include/package.
REQ-036 The wrap-around search is a sub-module rr_pri_enc: inputs req vector and start pointer; outputs winner index and valid.

Verification
REQ-037 Single master: m2 reads 0x4010, slv_wait=0 -> gnt=0b0100 in the same cycle, msts_busy=0, rr_ptr=3 next cycle.
REQ-038 Round-robin: all 4 masters request continuously, slv_wait=0, RR_EN=1 -> gnt_num sequence 0,1,2,3,0; losers busy=1.
REQ-039 Wait lock: m1 writes 0x1000, slv_wait=1 for 3 cycles while m0 requests -> gnt stays 0b0010 for 4 cycles and m0 busy throughout; m0 is granted the cycle after release.
REQ-040 Timeout: TMO_CYCLES=4, slv_wait stuck at 1 -> tmo_pulse high in HOLD cycle 4, owner busy=0 that cycle, tmo_flag stays 1 until tmo_clr.
REQ-041 Fixed priority: RR_EN=0 with m3 and m1 requesting -> m1 always granted and m3 busy.
REQ-042 Reset mid-HOLD: ireset pulsed while m2 is held -> all state zero; with m2 and m3 requesting afterwards, m2 is granted (search starts at 0).

Source files
------------

// File: rtl/dm_bus_arbiter_pkg.sv
// Shared DM interconnect definitions: bus field layout, FSM encodings and pointer helper.
package dm_bus_arbiter_pkg;

    localparam int BUS_W  = 26;
    localparam int WE_BIT = 25;
    localparam int RE_BIT = 24;
    localparam int IDX_W  = 3;
    localparam int CNT_W  = 8;

    // Field order mirrors the bit offsets: ramwe=25, ramre=24, ramadr=23:8, ramdout=7:0.
    typedef struct packed {
        logic        we;
        logic        re;
        logic [15:0] adr;
        logic [7:0]  dout;
    } dm_req_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_t;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx, input int n);
        return (int'(idx) >= n - 1) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/dm_bus_arbiter_if.sv
// DM bus bundle between the bus masters (master modport) and the arbiter (slave modport).
interface dm_bus_arbiter_if #(
    parameter int NUM_MSTS = 4
);
    import dm_bus_arbiter_pkg::*;

    logic [NUM_MSTS*BUS_W-1:0] msts_outs;
    logic                      slv_wait;
    logic                      tmo_clr;
    logic [15:0]               ramadr;
    logic [7:0]                ramdout;
    logic                      ramre;
    logic                      ramwe;
    logic [NUM_MSTS-1:0]       gnt;
    logic [IDX_W-1:0]          gnt_num;
    logic [NUM_MSTS-1:0]       msts_busy;
    logic                      tmo_pulse;
    logic                      tmo_flag;

    modport master (
        output msts_outs, slv_wait, tmo_clr,
        input  ramadr, ramdout, ramre, ramwe, gnt, gnt_num, msts_busy, tmo_pulse, tmo_flag
    );

    modport slave (
        input  msts_outs, slv_wait, tmo_clr,
        output ramadr, ramdout, ramre, ramwe, gnt, gnt_num, msts_busy, tmo_pulse, tmo_flag
    );

endinterface

// File: rtl/dm_bus_arbiter_rr_pri_enc.sv
// Wrap-around priority encoder: first requester at or after start, wrapping modulo N.
module rr_pri_enc
    import dm_bus_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        // NOTE: every output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        idx   = '0;
        valid = 1'b0;
        // Upper segment [start..N-1] is searched before the wrapped segment [0..start-1].
        for (int i = 0; i < N; i++) begin
            if (!valid && req[i] && (IDX_W'(i) >= start)) begin
                valid = 1'b1;
                idx   = IDX_W'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!valid && req[i] && (IDX_W'(i) < start)) begin
                valid = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/dm_bus_arbiter.sv
// DM bus arbiter: zero-latency grant in IDLE, grant lock while the slave waits, forced completion on timeout.
module dm_bus_arbiter
    import dm_bus_arbiter_pkg::*;
#(
    parameter int NUM_MSTS   = 4,
    parameter int RR_EN      = 1,
    parameter int TMO_CYCLES = 255
) (
    input  logic            cp2,
    input  logic            ireset,
    dm_bus_arbiter_if.slave bus
);

    arb_state_t       state, state_nxt;
    logic [IDX_W-1:0] owner, owner_nxt;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0] tmo_cnt, tmo_cnt_nxt;
    logic             tmo_flag;

    logic [NUM_MSTS-1:0] req;
    dm_req_t             fld [NUM_MSTS];
    logic [IDX_W-1:0]    win_idx;
    logic                win_vld;
    logic [IDX_W-1:0]    search_start;

    logic                gnt_vld;
    logic [IDX_W-1:0]    gnt_idx;
    logic                owner_req;
    logic                done;
    logic                forced;
    logic [NUM_MSTS-1:0] gnt;
    logic [NUM_MSTS-1:0] busy;
    dm_req_t             sel;

    for (genvar g = 0; g < NUM_MSTS; g++) begin : g_unpack
        assign fld[g] = bus.msts_outs[g*BUS_W +: BUS_W];
        assign req[g] = bus.msts_outs[g*BUS_W + WE_BIT] | bus.msts_outs[g*BUS_W + RE_BIT];
    end

    assign search_start = (RR_EN != 0) ? rr_ptr : '0;

    rr_pri_enc #(.N(NUM_MSTS)) u_rr_pri_enc (
        .req   (req),
        .start (search_start),
        .idx   (win_idx),
        .valid (win_vld)
    );

    always_comb begin
        owner_req = 1'b0;
        for (int i = 0; i < NUM_MSTS; i++) begin
            if (IDX_W'(i) == owner) owner_req = req[i];
        end
    end

    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        rr_ptr_nxt  = rr_ptr;
        tmo_cnt_nxt = tmo_cnt;
        gnt_vld     = 1'b0;
        gnt_idx     = '0;
        done        = 1'b0;
        forced      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (win_vld) begin
                    gnt_vld = 1'b1;
                    gnt_idx = win_idx;
                    if (bus.slv_wait) begin
                        state_nxt   = ST_HOLD;
                        owner_nxt   = win_idx;
                        tmo_cnt_nxt = 8'd1;
                    end else begin
                        done = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (!owner_req) begin
                    // Owner withdrew mid-wait: abandon without flagging a timeout.
                    state_nxt  = ST_IDLE;
                    rr_ptr_nxt = wrap_inc(owner, NUM_MSTS);
                end else begin
                    gnt_vld = 1'b1;
                    gnt_idx = owner;
                    if (!bus.slv_wait) begin
                        done = 1'b1;
                    end else if (tmo_cnt == CNT_W'(TMO_CYCLES)) begin
                        done   = 1'b1;
                        forced = 1'b1;
                    end else if (tmo_cnt != '1) begin
                        tmo_cnt_nxt = tmo_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (done) begin
            state_nxt  = ST_IDLE;
            rr_ptr_nxt = wrap_inc(gnt_idx, NUM_MSTS);
        end
    end

    always_comb begin
        gnt  = '0;
        busy = '0;
        sel  = '0;
        for (int i = 0; i < NUM_MSTS; i++) begin
            gnt[i] = gnt_vld && (gnt_idx == IDX_W'(i));
            // Losers stall unconditionally; the winner stalls only while the slave waits.
            busy[i] = req[i] && (gnt[i] ? (bus.slv_wait && !forced) : 1'b1);
            if (gnt[i]) sel = fld[i];
        end
    end

    assign bus.gnt       = gnt;
    assign bus.gnt_num   = gnt_vld ? gnt_idx : '0;
    assign bus.msts_busy = busy;
    assign bus.ramadr    = sel.adr;
    assign bus.ramdout   = sel.dout;
    assign bus.ramwe     = sel.we;
    assign bus.ramre     = sel.re & ~sel.we;
    assign bus.tmo_pulse = forced;
    assign bus.tmo_flag  = tmo_flag;

    always_ff @(posedge cp2 or posedge ireset) begin
        if (ireset) begin
            state    <= ST_IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            tmo_cnt  <= '0;
            tmo_flag <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
            state   <= state_nxt;
            owner   <= owner_nxt;
            rr_ptr  <= rr_ptr_nxt;
            tmo_cnt <= tmo_cnt_nxt;
            if (forced)           tmo_flag <= 1'b1;
            else if (bus.tmo_clr) tmo_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// Directed bench: round-robin/timeout instance (TMO_CYCLES=4) plus a fixed-priority instance.
module tb_dm_bus_arbiter;
    import dm_bus_arbiter_pkg::*;

    logic cp2 = 1'b0;
    logic ireset;
    always #5 cp2 = ~cp2;

    dm_bus_arbiter_if #(.NUM_MSTS(4)) bus_a ();
    dm_bus_arbiter_if #(.NUM_MSTS(4)) bus_b ();

    dm_bus_arbiter #(.NUM_MSTS(4), .RR_EN(1), .TMO_CYCLES(4)) u_dut_rr (
        .cp2    (cp2),
        .ireset (ireset),
        .bus    (bus_a.slave)
    );

    dm_bus_arbiter #(.NUM_MSTS(4), .RR_EN(0), .TMO_CYCLES(255)) u_dut_fp (
        .cp2    (cp2),
        .ireset (ireset),
        .bus    (bus_b.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [25:0] mk(input logic we, input logic re, input logic [15:0] adr,
                                       input logic [7:0] dout);
        return {we, re, adr, dout};
    endfunction

    task automatic set_a(input int i, input logic [25:0] v);
        bus_a.msts_outs[i*26 +: 26] = v;
    endtask

    task automatic set_b(input int i, input logic [25:0] v);
        bus_b.msts_outs[i*26 +: 26] = v;
    endtask

    task automatic tick();
        @(posedge cp2);
        @(negedge cp2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int exp_num [5];
        exp_num = '{0, 1, 2, 3, 0};

        ireset          = 1'b1;
        bus_a.msts_outs = '0;
        bus_a.slv_wait  = 1'b0;
        bus_a.tmo_clr   = 1'b0;
        bus_b.msts_outs = '0;
        bus_b.slv_wait  = 1'b0;
        bus_b.tmo_clr   = 1'b0;
        @(negedge cp2);
        @(negedge cp2);
        #1;
        check("rst_gnt",     bus_a.gnt, 0);
        check("rst_gnt_num", bus_a.gnt_num, 0);
        check("rst_busy",    bus_a.msts_busy, 0);
        check("rst_flag",    bus_a.tmo_flag, 0);
        check("rst_pulse",   bus_a.tmo_pulse, 0);
        check("rst_bus",     {bus_a.ramwe, bus_a.ramre, bus_a.ramadr, bus_a.ramdout}, 0);
        @(negedge cp2);
        ireset = 1'b0;

        // Single master m2 read, zero-latency grant
        set_a(2, mk(0, 1, 16'h4010, 8'h00));
        #1;
        check("single_gnt",     bus_a.gnt, 4'b0100);
        check("single_gnt_num", bus_a.gnt_num, 2);
        check("single_busy",    bus_a.msts_busy, 0);
        check("single_adr",     bus_a.ramadr, 16'h4010);
        check("single_re_we",   {bus_a.ramre, bus_a.ramwe}, 2'b10);
        tick();
        // rr_ptr is now 3: m3 beats m1
        set_a(2, 0);
        set_a(1, mk(1, 0, 16'h1111, 8'h11));
        set_a(3, mk(0, 1, 16'h3333, 8'h00));
        #1;
        check("ptr3_gnt",  bus_a.gnt, 4'b1000);
        check("ptr3_busy", bus_a.msts_busy, 4'b0010);
        check("ptr3_adr",  bus_a.ramadr, 16'h3333);
        tick();
        #1;
        check("ptr0_gnt",  bus_a.gnt, 4'b0010);
        check("ptr0_busy", bus_a.msts_busy, 4'b1000);
        check("ptr0_wr",   {bus_a.ramwe, bus_a.ramdout}, {1'b1, 8'h11});
        tick();

        // Move rr_ptr from 2 to 0 via a lone m3 access
        bus_a.msts_outs = '0;
        set_a(3, mk(0, 1, 16'h3000, 8'h00));
        #1;
        check("prep_gnt", bus_a.gnt, 4'b1000);
        tick();

        // All four request: 0,1,2,3,0; m0 sets both re and we (write)
        set_a(0, mk(1, 1, 16'h0AAA, 8'h5A));
        set_a(1, mk(0, 1, 16'h1AAA, 8'h00));
        set_a(2, mk(0, 1, 16'h2AAA, 8'h00));
        set_a(3, mk(0, 1, 16'h3AAA, 8'h00));
        #1;
        check("rw_both_is_write", {bus_a.ramwe, bus_a.ramre}, 2'b10);
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("rr_num_%0d", k),  bus_a.gnt_num, exp_num[k]);
            check($sformatf("rr_busy_%0d", k), bus_a.msts_busy, 4'hF & ~(4'b1 << exp_num[k]));
            tick();
        end

        // Wait lock: m1 held for 3 wait cycles plus the completing cycle; rr_ptr=1
        bus_a.msts_outs = '0;
        set_a(0, mk(0, 1, 16'h0100, 8'h00));
        set_a(1, mk(1, 0, 16'h1000, 8'hA5));
        bus_a.slv_wait = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) bus_a.slv_wait = 1'b0;
            #1;
            check($sformatf("lock_gnt_%0d", k),  bus_a.gnt, 4'b0010);
            check($sformatf("lock_busy_%0d", k), bus_a.msts_busy, (k < 3) ? 4'b0011 : 4'b0001);
            check($sformatf("lock_adr_%0d", k),  bus_a.ramadr, 16'h1000);
            tick();
        end
        set_a(1, 0);
        #1;
        check("after_lock_gnt",  bus_a.gnt, 4'b0001);
        check("after_lock_busy", bus_a.msts_busy, 0);
        tick();

        // Timeout with TMO_CYCLES=4; clear asserted in the forced cycle loses to the set
        bus_a.msts_outs = '0;
        set_a(3, mk(0, 1, 16'h3000, 8'h00));
        bus_a.slv_wait = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) bus_a.tmo_clr = 1'b1;
            #1;
            check($sformatf("tmo_pulse_%0d", k), bus_a.tmo_pulse, (k == 4));
            check($sformatf("tmo_busy_%0d", k),  bus_a.msts_busy, (k == 4) ? 4'b0000 : 4'b1000);
            check($sformatf("tmo_gnt_%0d", k),   bus_a.gnt, 4'b1000);
            check($sformatf("tmo_flag_pre_%0d", k), bus_a.tmo_flag, 0);
            tick();
        end
        bus_a.tmo_clr   = 1'b0;
        bus_a.msts_outs = '0;
        bus_a.slv_wait  = 1'b0;
        #1;
        check("tmo_flag_set",   bus_a.tmo_flag, 1);
        check("tmo_pulse_gone", bus_a.tmo_pulse, 0);
        check("tmo_idle_gnt",   bus_a.gnt, 0);
        tick();
        #1;
        check("tmo_flag_sticky", bus_a.tmo_flag, 1);
        bus_a.tmo_clr = 1'b1;
        #1;
        check("tmo_flag_clr_same_cycle", bus_a.tmo_flag, 1);
        tick();
        bus_a.tmo_clr = 1'b0;
        #1;
        check("tmo_flag_cleared", bus_a.tmo_flag, 0);

        // Abort: owner m2 drops its request while held; rr_ptr must advance to 3
        set_a(2, mk(0, 1, 16'h2000, 8'h00));
        bus_a.slv_wait = 1'b1;
        #1;
        check("abort_enter_gnt", bus_a.gnt, 4'b0100);
        tick();
        set_a(2, 0);
        #1;
        check("abort_busy",  bus_a.msts_busy, 0);
        check("abort_pulse", bus_a.tmo_pulse, 0);
        tick();
        bus_a.slv_wait = 1'b0;
        set_a(0, mk(0, 1, 16'h0200, 8'h00));
        set_a(3, mk(0, 1, 16'h3200, 8'h00));
        #1;
        check("abort_ptr_gnt", bus_a.gnt, 4'b1000);
        check("abort_no_flag", bus_a.tmo_flag, 0);
        tick();

        // Reset mid-HOLD with rr_ptr=3 beforehand
        bus_a.msts_outs = '0;
        set_a(2, mk(0, 1, 16'h2400, 8'h00));
        #1;
        check("rh_prep_gnt", bus_a.gnt, 4'b0100);
        tick();
        bus_a.slv_wait = 1'b1;
        #1;
        check("rh_enter_gnt", bus_a.gnt, 4'b0100);
        tick();
        #1;
        check("rh_hold_gnt", bus_a.gnt, 4'b0100);
        #2;
        ireset          = 1'b1;
        bus_a.msts_outs = '0;
        bus_a.slv_wait  = 1'b0;
        #1;
        check("rh_rst_gnt",     bus_a.gnt, 0);
        check("rh_rst_gnt_num", bus_a.gnt_num, 0);
        check("rh_rst_busy",    bus_a.msts_busy, 0);
        check("rh_rst_flag",    bus_a.tmo_flag, 0);
        @(negedge cp2);
        ireset = 1'b0;
        set_a(2, mk(0, 1, 16'h2400, 8'h00));
        set_a(3, mk(0, 1, 16'h3400, 8'h00));
        #1;
        check("rh_first_gnt", bus_a.gnt, 4'b0100);
        check("rh_first_busy", bus_a.msts_busy, 4'b1000);
        tick();
        #1;
        check("rh_second_gnt", bus_a.gnt, 4'b1000);
        tick();

        // Fixed priority: m1 always beats m3
        set_b(1, mk(0, 1, 16'h1500, 8'h00));
        set_b(3, mk(0, 1, 16'h3500, 8'h00));
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("fp_gnt_%0d", k),  bus_b.gnt, 4'b0010);
            check($sformatf("fp_num_%0d", k),  bus_b.gnt_num, 1);
            check($sformatf("fp_busy_%0d", k), bus_b.msts_busy, 4'b1000);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
